start_edge_qualifier: RTL and testbench
=======================================

# start_edge_qualifier

Parametrised UART start-bit qualifier: synchronises raw RX data, detects a mark-to-space edge, and accepts or rejects the start bit by majority count over a configurable oversampled window. It succeeds the fixed 8-sample detector. It adds a built-in synchroniser, a re-arm handshake so it can run without reset between frames, an enable gate, and false-start reporting. It sits between the RX pin and the UART receive bit-timing/shift logic.

## Interface
- OVERSAMPLE, 16: clk cycles per nominal bit; bounds WINDOW.
- WINDOW, 8: samples in the qualification window, including the edge sample; legal 2..OVERSAMPLE.
- THRESHOLD, 4: minimum space samples in the window to accept; legal 1..WINDOW.
- SYNC_STAGES, 2: synchroniser flops on data; legal ≥2.
- clk  input  1  sample clock at OVERSAMPLE x bitrate.
- rst_n  input  1  reset, asynchronous, active-low.
- data  input  1  raw asynchronous RX line (1 = mark, 0 = space).
- enable  input  1  qualifier enable; low = no new edges, aborts qualification.
- rearm  input  1  pulse; returns DETECTED to IDLE.
- start_bit_detected  output  1  level, high from acceptance until rearm.
- start_pulse  output  1  one-cycle strobe on acceptance.
- false_start  output  1  one-cycle strobe on rejection.
- false_start_count  output  8  saturating count of rejections.

## Operation
- Synchroniser: SYNC_STAGES flops on data, reset to 1. Synced sample s. Register s_prev, reset to 1, updated every cycle in all states.
- Edge: s_prev=1 && s=0.
- FSM states IDLE, QUALIFY, DETECTED; reset state IDLE.
- IDLE: on edge with enable=1 -> QUALIFY, sample_cnt=1, space_cnt=1. Otherwise stay.
- QUALIFY: each cycle sample_cnt+1, space_cnt + (s==0).
  - When sample_cnt reaches WINDOW, the decision uses the updated space_cnt:
    - space_cnt ≥ THRESHOLD -> DETECTED; start_bit_detected=1; start_pulse=1 for one cycle.
    - Else -> IDLE; false_start=1 for one cycle; false_start_count+1, saturating at 255.
  - enable=0 in QUALIFY -> IDLE immediately. No strobe, no count change.
- DETECTED: hold start_bit_detected=1. Ignore edges and enable. rearm=1 -> IDLE, start_bit_detected=0 after that edge.
- rearm outside DETECTED: ignored.
- After rearm, a new falling edge is required. A line still at space does not retrigger.
- Counter widths: sample_cnt and space_cnt are $clog2(WINDOW+1) bits. No wrap is possible because the decision happens at WINDOW.
- false_start_count is cleared only by rst_n.

## Timing
- Reset (async assert): state=IDLE, all outputs 0, false_start_count=0, sync flops and s_prev=1. Taking effect mid-QUALIFY or in DETECTED discards the frame immediately.
- Reset release: the first edge requires a real 1->0 on the synced line. A line held low through reset produces no detection.
- Latency, with the data falling edge first captured at clk edge 1:
  - QUALIFY is entered at edge SYNC_STAGES+1.
  - The decision is registered at edge SYNC_STAGES+WINDOW.
  - start_bit_detected, start_pulse or false_start are visible after that edge.
- start_pulse and false_start are mutually exclusive and never high for two consecutive cycles.
- Simultaneous events:
  - rearm and edge in the same cycle in DETECTED: go to IDLE. That edge is not used.
  - A glitch during QUALIFY that returns to space does not restart the window.
- Back-to-back: after rejection the FSM returns to IDLE. A new edge detected on the very next cycle starts a new window.

## Test plan
- Defaults (SYNC_STAGES=2, WINDOW=8, THRESHOLD=4): clean low from edge 1 -> start_bit_detected and start_pulse rise after edge 10; pulse 1 cycle; level holds until rearm.
- 2-cycle low glitch then mark -> false_start after edge 10; false_start_count=1; start_bit_detected stays 0; the next clean low is accepted.
- Boundary: exactly 4 space samples in window -> accepted. Exactly 3 -> rejected. Repeat with WINDOW=16, THRESHOLD=9: 9 accepted, 8 rejected.
- enable dropped mid-QUALIFY -> IDLE, no strobes, count unchanged. enable low at edge time -> no QUALIFY entry.
- rearm while line still low -> no retrigger. Line to mark then low -> detection 10 cycles after the new edge. rearm in IDLE -> no effect.
- rst_n asserted mid-QUALIFY and in DETECTED -> outputs 0 immediately. 300 glitches -> false_start_count saturates at 255.

Source files
------------

// File: rtl/start_edge_qualifier.sv
// start_edge_qualifier
// UART start-bit qualifier. Synchronises the raw RX line, detects a
// mark-to-space edge, then counts space samples over a WINDOW-sample
// window and accepts the start bit when the count reaches THRESHOLD.
// Accepted starts hold start_bit_detected until rearm. Rejected starts
// pulse false_start and bump a saturating counter.

module start_edge_qualifier #(
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned WINDOW      = 8,
   parameter int unsigned THRESHOLD   = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data,
   input  logic       enable,
   input  logic       rearm,
   output logic       start_bit_detected,
   output logic       start_pulse,
   output logic       false_start,
   output logic [7:0] false_start_count
);

   localparam int unsigned CW = $clog2(WINDOW + 1);

   generate
      if (!(WINDOW >= 2 && WINDOW <= OVERSAMPLE &&
            THRESHOLD >= 1 && THRESHOLD <= WINDOW &&
            SYNC_STAGES >= 2)) begin : g_bad_cfg
         $error("start_edge_qualifier: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      QUALIFY,
      DETECTED
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_vld;
   logic                   s;
   logic                   s_prev;
   logic                   flushed;
   logic                   seen_mark;
   logic                   fall;
   logic [CW-1:0]          sample_cnt;
   logic [CW-1:0]          space_cnt;
   logic [CW-1:0]          space_next;
   logic                   last_sample;
   logic                   accept;

   assign s       = sync_q[SYNC_STAGES-1];
   assign flushed = sync_vld[SYNC_STAGES-1];

   // Synchroniser chain, previous-sample register and post-reset arming.
   // The chain resets to mark, so its first real samples after reset could
   // look like a falling edge if the line is held at space. seen_mark only
   // sets once a genuinely sampled mark has emerged from the chain, so the
   // first edge after reset must be a real 1->0 on the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '1;
         sync_vld  <= '0;
         s_prev    <= 1'b1;
         seen_mark <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], data};
         sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
         s_prev    <= s;
         seen_mark <= seen_mark | (flushed & s);
      end
   end

   // Edge detect and window bookkeeping for the current sample.
   always_comb begin
      fall        = seen_mark & s_prev & ~s;
      space_next  = space_cnt + {{(CW-1){1'b0}}, ~s};
      last_sample = (sample_cnt == CW'(WINDOW - 1));
      accept      = (space_next >= CW'(THRESHOLD));
   end

   // Qualification FSM with registered level, strobes and reject counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         sample_cnt         <= '0;
         space_cnt          <= '0;
         start_bit_detected <= 1'b0;
         start_pulse        <= 1'b0;
         false_start        <= 1'b0;
         false_start_count  <= '0;
      end else begin
         start_pulse <= 1'b0;
         false_start <= 1'b0;
         case (state)
            IDLE: begin
               if (fall && enable) begin
                  state      <= QUALIFY;
                  sample_cnt <= CW'(1);
                  space_cnt  <= CW'(1);
               end
            end
            QUALIFY: begin
               if (!enable) begin
                  state <= IDLE;
               end else begin
                  sample_cnt <= sample_cnt + CW'(1);
                  space_cnt  <= space_next;
                  if (last_sample) begin
                     if (accept) begin
                        state              <= DETECTED;
                        start_bit_detected <= 1'b1;
                        start_pulse        <= 1'b1;
                     end else begin
                        state       <= IDLE;
                        false_start <= 1'b1;
                        if (false_start_count != 8'hFF) begin
                           false_start_count <= false_start_count + 8'd1;
                        end
                     end
                  end
               end
            end
            DETECTED: begin
               if (rearm) begin
                  state              <= IDLE;
                  start_bit_detected <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_start_edge_qualifier.sv
// Bench for start_edge_qualifier. Two instances: defaults (W=8, T=4) and
// W=16, T=9. Each frame pushes its expected outcome (accept/reject, strobe
// cycle, reject count) onto a per-instance queue; a negedge monitor pops
// and compares whenever a strobe appears.

module tb_start_edge_qualifier;

   typedef struct {
      bit acc;
      int cyc;
      int fc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       data_a = 1'b1, enable_a = 1'b1, rearm_a = 1'b0;
   logic       data_b = 1'b1, enable_b = 1'b1, rearm_b = 1'b0;
   logic       det_a, pulse_a, fs_a;
   logic       det_b, pulse_b, fs_b;
   logic [7:0] fc_a, fc_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   exp_fc_a = 0;
   int   exp_fc_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   bit   prev_strobe[2] = '{1'b0, 1'b0};

   start_edge_qualifier dut_a (
      .clk(clk), .rst_n(rst_n), .data(data_a), .enable(enable_a), .rearm(rearm_a),
      .start_bit_detected(det_a), .start_pulse(pulse_a), .false_start(fs_a),
      .false_start_count(fc_a)
   );

   start_edge_qualifier #(
      .OVERSAMPLE(16), .WINDOW(16), .THRESHOLD(9), .SYNC_STAGES(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .data(data_b), .enable(enable_b), .rearm(rearm_b),
      .start_bit_detected(det_b), .start_pulse(pulse_b), .false_start(fs_b),
      .false_start_count(fc_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int qsz(input int sel);
      return (sel != 0) ? q_b.size() : q_a.size();
   endfunction

   task automatic mon(input int sel, input logic p, input logic f, input logic d,
                      input logic [7:0] fc);
      exp_t  e;
      string nm;
      nm = (sel != 0) ? "b" : "a";
      if (p || f) begin
         check({nm, "_exclusive"}, int'(p & f), 0);
         check({nm, "_back_to_back"}, int'(prev_strobe[sel]), 0);
         check({nm, "_strobe_expected"}, int'(qsz(sel) != 0), 1);
         if (qsz(sel) != 0) begin
            if (sel != 0) e = q_b.pop_front();
            else          e = q_a.pop_front();
            check({nm, "_accept"}, int'(p), int'(e.acc));
            check({nm, "_strobe_cycle"}, cyc, e.cyc);
            check({nm, "_fs_count"}, int'(fc), e.fc);
            check({nm, "_level"}, int'(d), int'(e.acc));
         end
      end
      prev_strobe[sel] = p | f;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, pulse_a, fs_a, det_a, fc_a);
         mon(1, pulse_b, fs_b, det_b, fc_b);
      end
   end

   task automatic set_data(input int sel, input logic v);
      if (sel != 0) data_b = v;
      else          data_a = v;
   endtask

   // Drive one frame: bit i of pat is the line value captured at edge i+1.
   task automatic frame(input int sel, input logic [31:0] pat, input logic tail);
      int   w, thr, zeros;
      exp_t e;
      w     = (sel != 0) ? 16 : 8;
      thr   = (sel != 0) ? 9 : 4;
      zeros = 0;
      for (int i = 0; i < w; i++) if (!pat[i]) zeros++;
      @(negedge clk);
      e.acc = (zeros >= thr);
      e.cyc = cyc + 2 + w;
      if (sel != 0) begin
         if (!e.acc && exp_fc_b < 255) exp_fc_b++;
         e.fc = exp_fc_b;
         q_b.push_back(e);
      end else begin
         if (!e.acc && exp_fc_a < 255) exp_fc_a++;
         e.fc = exp_fc_a;
         q_a.push_back(e);
      end
      for (int i = 0; i < w; i++) begin
         set_data(sel, pat[i]);
         @(negedge clk);
      end
      set_data(sel, tail);
      for (int k = 0; k < 40 && qsz(sel) != 0; k++) @(negedge clk);
      if (qsz(sel) != 0) begin
         check((sel != 0) ? "b_strobe_timeout" : "a_strobe_timeout", qsz(sel), 0);
         if (sel != 0) q_b.delete();
         else          q_a.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic do_rearm(input int sel);
      @(negedge clk);
      if (sel != 0) rearm_b = 1'b1;
      else          rearm_a = 1'b1;
      @(negedge clk);
      rearm_a = 1'b0;
      rearm_b = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_det_a", int'(det_a), 0);
      check("rst_pulse_a", int'(pulse_a), 0);
      check("rst_fs_a", int'(fs_a), 0);
      check("rst_fc_a", int'(fc_a), 0);
      check("rst_det_b", int'(det_b), 0);
      check("rst_fc_b", int'(fc_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // Clean low held: accept, level holds, edges in DETECTED ignored
      frame(0, 32'h0000_0000, 1'b0);
      repeat (5) @(negedge clk);
      check("a_hold", int'(det_a), 1);
      data_a = 1'b1;
      repeat (3) @(negedge clk);
      data_a = 1'b0;
      repeat (12) @(negedge clk);
      check("a_hold_ignore_edge", int'(det_a), 1);
      // rearm with line still low: no retrigger
      do_rearm(0);
      check("a_rearm_clear", int'(det_a), 0);
      repeat (15) @(negedge clk);
      check("a_no_retrigger", int'(det_a), 0);
      data_a = 1'b1;
      repeat (4) @(negedge clk);
      frame(0, 32'h0000_0000, 1'b1);
      do_rearm(0);
      check("a_rearm_clear2", int'(det_a), 0);

      // Glitch rejected, then clean low accepted
      frame(0, 32'hFFFF_FFFC, 1'b1);
      check("a_glitch_no_level", int'(det_a), 0);
      frame(0, 32'h0000_0000, 1'b1);
      do_rearm(0);

      // Boundaries for W=8, T=4
      frame(0, 32'hFFFF_FFF0, 1'b1);
      do_rearm(0);
      frame(0, 32'hFFFF_FFF8, 1'b1);
      frame(0, 32'hFFFF_FF56, 1'b1);
      do_rearm(0);

      // Boundaries for W=16, T=9
      frame(1, 32'hFFFF_FE00, 1'b1);
      do_rearm(1);
      frame(1, 32'hFFFF_FF00, 1'b1);
      check("b_count_after_reject", int'(fc_b), exp_fc_b);

      // enable dropped mid-QUALIFY
      @(negedge clk);
      data_a = 1'b0;
      repeat (4) @(negedge clk);
      enable_a = 1'b0;
      @(negedge clk);
      enable_a = 1'b1;
      repeat (12) @(negedge clk);
      data_a = 1'b1;
      repeat (5) @(negedge clk);
      check("a_en_drop_count", int'(fc_a), exp_fc_a);
      check("a_en_drop_level", int'(det_a), 0);

      // enable low at edge time
      enable_a = 1'b0;
      data_a   = 1'b0;
      repeat (12) @(negedge clk);
      data_a = 1'b1;
      repeat (5) @(negedge clk);
      enable_a = 1'b1;
      repeat (3) @(negedge clk);
      check("a_en_low_level", int'(det_a), 0);
      check("a_en_low_count", int'(fc_a), exp_fc_a);

      // rearm in IDLE has no effect
      do_rearm(0);
      check("a_rearm_idle_level", int'(det_a), 0);
      check("a_rearm_idle_count", int'(fc_a), exp_fc_a);
      frame(0, 32'h0000_0000, 1'b1);
      do_rearm(0);

      // Reset mid-QUALIFY
      @(negedge clk);
      data_a = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstq_det", int'(det_a), 0);
      check("rstq_pulse", int'(pulse_a), 0);
      check("rstq_fs", int'(fs_a), 0);
      check("rstq_fc", int'(fc_a), 0);
      check("rstq_fc_b", int'(fc_b), 0);
      exp_fc_a = 0;
      exp_fc_b = 0;
      data_a   = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);

      // Reset in DETECTED, line held low through reset
      frame(0, 32'h0000_0000, 1'b1);
      check("rstd_pre_level", int'(det_a), 1);
      @(negedge clk);
      data_a = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rstd_det", int'(det_a), 0);
      check("rstd_pulse", int'(pulse_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("rst_low_line_level", int'(det_a), 0);
      data_a = 1'b1;
      repeat (6) @(negedge clk);

      // Saturation of the reject counter
      for (int i = 0; i < 300; i++) frame(0, 32'hFFFF_FFFC, 1'b1);
      check("a_fc_saturate", int'(fc_a), 255);
      frame(0, 32'h0000_0000, 1'b1);
      do_rearm(0);

      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
